seq_neuron: RTL and testbench
=============================

Name: seq_neuron

Overview:
- Sequential, parametrised neuron for the FNN datapath.
- Evaluates out = sat(ReLU((sum(in[i]*w[i]) + bias*BIAS_SCALE) >> SHIFT)) with one MAC per clock instead of a flat combinational tree.
- Operands are sign-magnitude and captured on a start handshake. The result is held with a one-cycle done pulse.
- Sits between the layer controller and the layer output register. Many instances run concurrently, one per neuron.

Parameters:
- N_IN, 62, number of inputs and weights per neuron (>=1).
- DATA_W, 8, sign-magnitude word width. MSB is the sign, DATA_W-1 magnitude bits.
- BIAS_SCALE, 127, multiplier applied to the bias magnitude before it is added to the sum.
- SHIFT, 9, arithmetic right shift applied to the biased sum.
- LEAK_SHIFT, 3, extra shift for the negative slope. Used only with LEAKY_RELU_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- bias  in  DATA_W  sign-magnitude bias.
- weight  in  N_IN*DATA_W  weights. Element i is at [i*DATA_W +: DATA_W].
- in  in  N_IN*DATA_W  activations, same packing as weight.
- busy  out  1  high while a computation is in flight.
- done  out  1  one-cycle pulse when out is updated.
- out  out  DATA_W  sign-magnitude result. Held until the next done.

Behaviour:
- Reset: one clock, synchronous active-high (rst). Forces state to IDLE and clears busy, done, out, the index and the accumulator. A reset mid-operation abandons the computation, and no done is produced.
- Arithmetic:
  - Signed two's-complement accumulator. Width localparam ACC_W = 2*(DATA_W-1) + $clog2(N_IN+1) + $clog2(BIAS_SCALE+1) + 1, so no overflow is possible.
  - Each product has magnitude |in|*|w| and sign in.sign XOR w.sign.
  - Negative zero (sign=1, magnitude=0) is treated as 0.
- State machine:
  - IDLE: done=0 except in the pulse cycle. If start=1, latch bias, weight and in into internal registers, set acc <= ±|bias|*BIAS_SCALE, idx <= 0, busy <= 1, and go to ACCUM. Inputs may change freely after this capture edge.
  - ACCUM: each cycle acc <= acc + product[idx], idx <= idx+1. When idx==N_IN-1 is consumed, go to FINAL. This takes exactly N_IN cycles.
  - FINAL: r = acc.
    - If r <= 0, out <= 0.
    - Otherwise q = r >> SHIFT, and out <= {0, min(q, 2^(DATA_W-1)-1)}.
    - Same edge: done <= 1, busy <= 0, go to IDLE.
- Latency: start sampled at edge k, then out and done are valid after edge k+N_IN+1. Throughput is one result per N_IN+2 cycles.
- done is exactly one cycle wide. A start present while done=1 (state IDLE) is accepted, so back-to-back operation is allowed.
- start while busy=1 is ignored: no queueing, and the operation in flight is unaffected.
- out is never negative zero, and only changes on a done edge or on reset.

Optional Feature:
- Macro: LEAKY_RELU_EN.
- Defined: for r < 0, m = (-r) >> (SHIFT+LEAK_SHIFT), and out <= {1, min(m, 2^(DATA_W-1)-1)}. If m==0, out <= 0 (all zeros, never negative zero). Positive path is unchanged.
- Undefined: plain ReLU, so every r <= 0 gives out=0. LEAK_SHIFT is unused.
- Latency and handshake are identical in both builds.

Test Plan:
- Mixed-sign case (defaults; upper 58 elements zero):
  - Stimulus: in[3:0] = {-127, -103, +93, +100}, w[3:0] = {+2, -3, +4, -5}, bias = +100, pulse start.
  - Expected: sum = -73, r = 12627. done exactly 63 cycles after the start edge, out = 8'h18 (24), busy high for the 63 cycles between.
- All zero: in, weight and bias all zero -> out = 8'h00, done pulses once.
- Saturation: all in = +127, all w = +127, bias = 0.
  - Expected: r = 999998, out = 8'h7F.
- Negative result: all in and weight zero, bias = -100 (8'hE4).
  - Expected: r = -12700. out = 8'h00, or 8'h83 with LEAKY_RELU_EN (12700>>12 = 3).
- Handshake:
  - Assert start in the cycle where done=1 -> second result arrives N_IN+2 cycles after the first.
  - Assert start mid-ACCUM -> ignored, and the first result is unchanged.
- Reset mid-operation: rst high for one cycle at ACCUM idx=30.
  - Expected: busy=0, out=0, no done.
  - A new start afterwards produces the correct result for the new operands.

Source files
------------

// File: rtl/seq_neuron.sv
// Sequential sign-magnitude neuron: one MAC per clock, biased sum, shift, ReLU and saturate.
// Optional build macro LEAKY_RELU_EN enables a leaky negative slope scaled by LEAK_SHIFT.
module seq_neuron #(
  parameter int N_IN       = 62,
  parameter int DATA_W     = 8,
  parameter int BIAS_SCALE = 127,
  parameter int SHIFT      = 9,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        bias,
  input  logic [N_IN*DATA_W-1:0]   weight,
  input  logic [N_IN*DATA_W-1:0]   in,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        out
);
  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = 2 * MAG_W;
  localparam int ACC_W  = 2*(DATA_W-1) + $clog2(N_IN+1) + $clog2(BIAS_SCALE+1) + 1;
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'((2**MAG_W) - 1);

  if (N_IN < 1 || LEAK_SHIFT < 0) begin : g_param_check
    $error("seq_neuron: N_IN must be >= 1 and LEAK_SHIFT >= 0");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic signed [ACC_W-1:0]        acc;
  logic [N_IN-1:0][DATA_W-1:0]    x_r;
  logic [N_IN-1:0][DATA_W-1:0]    w_r;

  logic [DATA_W-1:0]              cur_x, cur_w;
  logic [PROD_W-1:0]              prod;
  logic signed [ACC_W-1:0]        prod_s;
  logic [ACC_W-1:0]               bias_mag;
  logic signed [ACC_W-1:0]        bias_s;
  logic signed [ACC_W-1:0]        q;
  logic [DATA_W-1:0]              res;
`ifdef LEAKY_RELU_EN
  logic signed [ACC_W-1:0]        nm;
`endif

  function automatic logic [MAG_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    return (v > MAX_S) ? MAG_W'(MAX_S) : v[MAG_W-1:0];
  endfunction

  // Magnitude-only multiply; a zero magnitude yields zero regardless of sign,
  // so negative-zero operands need no special handling.
  always_comb begin
    cur_x    = x_r[idx];
    cur_w    = w_r[idx];
    prod     = PROD_W'(cur_x[MAG_W-1:0]) * PROD_W'(cur_w[MAG_W-1:0]);
    prod_s   = (cur_x[DATA_W-1] ^ cur_w[DATA_W-1]) ? -$signed(ACC_W'(prod))
                                                   :  $signed(ACC_W'(prod));
    bias_mag = ACC_W'(bias[MAG_W-1:0]) * ACC_W'(BIAS_SCALE);
    bias_s   = bias[DATA_W-1] ? -$signed(bias_mag) : $signed(bias_mag);
  end

  always_comb begin
    q   = acc >>> SHIFT;
    res = '0;
    if (acc > 0) begin
      res = {1'b0, sat(q)};
    end
`ifdef LEAKY_RELU_EN
    nm = '0;
    if (acc < 0) begin
      nm = (-acc) >>> (SHIFT + LEAK_SHIFT);
      // A negative result that rounds to zero magnitude must come out as plain zero.
      if (nm != '0) res = {1'b1, sat(nm)};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      idx   <= '0;
      acc   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_r   <= in;
            w_r   <= weight;
            acc   <= bias_s;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + prod_s;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(N_IN - 1)) state <= FINAL;
        end
        FINAL: begin
          out   <= res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_neuron.sv
// Bench for seq_neuron: vector table plus scoreboard, with handshake, back-to-back and reset sequences.
module tb_seq_neuron;
  localparam int N_IN  = 62;
  localparam int NV    = 12;
  localparam int SHIFT = 9;
  localparam int LEAK  = 3;
  localparam int BS    = 127;

  logic               clk = 1'b0;
  logic               rst, start;
  logic [7:0]         b;
  logic [N_IN*8-1:0]  w, x;
  logic               busy, done;
  logic [7:0]         out;

  seq_neuron dut (
    .clk(clk), .rst(rst), .start(start), .bias(b), .weight(w), .in(x),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [7:0]        b;
    logic [N_IN*8-1:0] w;
    logic [N_IN*8-1:0] x;
    logic [7:0]        exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t tv[NV];
  sb_t  sb[$];
  int   tests = 0, fails = 0;
  int   cyc = 0, done_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic logic [7:0] model(input logic [7:0] bb, input logic [N_IN*8-1:0] ww,
                                       input logic [N_IN*8-1:0] xx);
    longint s, p, mx, mw, m;
    mx = bb[6:0];
    s = bb[7] ? -(mx * BS) : mx * BS;
    for (int i = 0; i < N_IN; i++) begin
      mx = xx[i*8 +: 7];
      mw = ww[i*8 +: 7];
      p  = mx * mw;
      s  = (xx[i*8+7] ^ ww[i*8+7]) ? s - p : s + p;
    end
    if (s > 0) begin
      m = s >>> SHIFT;
      return {1'b0, 7'((m > 127) ? 127 : m)};
    end
`ifdef LEAKY_RELU_EN
    if (s < 0) begin
      m = (-s) >>> (SHIFT + LEAK);
      if (m != 0) return {1'b1, 7'((m > 127) ? 127 : m)};
    end
`endif
    return 8'h00;
  endfunction

  function automatic logic [N_IN*8-1:0] rand_vec();
    logic [N_IN*8-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check({"out_", e.name}, out, e.exp);
      end
    end
  end

  // Drive one request from a negedge; returns at the negedge where done is seen.
  // ign_at >= 0 injects a stray start (not scoreboarded) that many cycles in.
  task automatic do_op(input vec_t v, input int ign_at, output int lat, output int busy_hi);
    int c0;
    b = v.b; w = v.w; x = v.x; start = 1'b1;
    sb.push_back('{v.name, v.exp});
    c0 = cyc;
    lat = -1;
    busy_hi = 0;
    for (int k = 0; k < N_IN + 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      b = 8'($urandom); w = rand_vec(); x = rand_vec();
      if (k == ign_at) start = 1'b1;
      if (done) begin
        lat = cyc - (c0 + 1);
        break;
      end
      if (busy) busy_hi++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bh, d1, dc0;
    rst = 1'b1; start = 1'b0; b = '0; w = '0; x = '0;

    for (int i = 0; i < NV; i++) begin
      tv[i].name = $sformatf("vec%0d", i);
      tv[i].b = '0; tv[i].w = '0; tv[i].x = '0; tv[i].exp = '0;
    end
    tv[0].name = "mixed"; tv[0].b = 8'h64;
    tv[0].x[31:0] = 32'hFF_E7_5D_64;
    tv[0].w[31:0] = 32'h02_83_04_85;
    tv[0].exp = 8'h18;
    tv[1].name = "zero"; tv[1].exp = 8'h00;
    tv[2].name = "sat";
    for (int i = 0; i < N_IN; i++) begin
      tv[2].x[i*8 +: 8] = 8'h7F; tv[2].w[i*8 +: 8] = 8'h7F;
    end
    tv[2].exp = 8'h7F;
    tv[3].name = "negbias"; tv[3].b = 8'hE4;
`ifdef LEAKY_RELU_EN
    tv[3].exp = 8'h83;
`else
    tv[3].exp = 8'h00;
`endif
    tv[4].name = "negzero"; tv[4].b = 8'h80;
    for (int i = 0; i < N_IN; i++) begin
      tv[4].x[i*8 +: 8] = 8'h80; tv[4].w[i*8 +: 8] = 8'hFF;
    end
    tv[4].exp = 8'h00;
    tv[5].name = "biasonly"; tv[5].b = 8'h7F; tv[5].exp = 8'h1F;
    tv[6].name = "negneg";
    tv[6].x[15:0] = 16'hB2_FF;
    tv[6].w[15:0] = 16'h32_E4;
    tv[6].exp = 8'h13;
    for (int i = 7; i < NV; i++) begin
      tv[i].b = 8'($urandom); tv[i].w = rand_vec(); tv[i].x = rand_vec();
      tv[i].exp = model(tv[i].b, tv[i].w, tv[i].x);
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      repeat (2) @(negedge clk);
      do_op(tv[i], -1, lat, bh);
      check({"lat_", tv[i].name}, lat, N_IN + 1);
      check({"busy_", tv[i].name}, bh, N_IN + 1);
      @(negedge clk);
      check({"pulse_", tv[i].name}, done, 0);
      check({"hold_", tv[i].name}, out, tv[i].exp);
    end

    // Back-to-back: next start issued in the done cycle.
    @(negedge clk);
    do_op(tv[0], -1, lat, bh);
    d1 = cyc;
    do_op(tv[2], -1, lat, bh);
    check("b2b_lat", lat, N_IN + 1);
    check("b2b_interval", cyc - d1, N_IN + 2);

    // Stray start mid-accumulation must be ignored.
    repeat (2) @(negedge clk);
    do_op(tv[6], 10, lat, bh);
    check("ign_lat", lat, N_IN + 1);
    @(negedge clk);
    dc0 = done_cnt;
    repeat (N_IN + 5) @(negedge clk);
    check("ign_no_extra_done", done_cnt, dc0);

    // Reset at idx=30 abandons the operation.
    b = tv[2].b; w = tv[2].w; x = tv[2].x; start = 1'b1;
    sb.push_back('{"aborted", tv[2].exp});
    repeat (31) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out", out, 0);
    check("abort_done", done, 0);
    sb.delete();
    dc0 = done_cnt;
    repeat (N_IN + 5) @(negedge clk);
    check("abort_no_done", done_cnt, dc0);
    check("abort_out_idle", out, 0);

    do_op(tv[0], -1, lat, bh);
    check("post_rst_lat", lat, N_IN + 1);
    @(negedge clk);
    check("post_rst_out", out, 8'h18);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
